lock_datapath: RTL and testbench
================================

// Module: lock_datapath
// PURPOSE
//  Datapath partner of the combination-lock control FSM. Consumes ShiftA/ShiftB/RSTA/Select
//  from the FSM and returns Pass/Reverse. Holds entered code A, staged new code S and stored
//  code B (4 BCD digits each), and scans a 4-digit common-anode 7-seg display per Select.
// PARAMETERS
//  DEFAULT_CODE  16'h1234  B value after RST (digit3 in [15:12])
//  REFRESH_DIV   17        scan counter width; digit advances when counter wraps (2^N clocks)
// PORTS
//  CLK       in   1   system clock
//  RST       in   1   asynchronous reset, active-high
//  Digit_In  in   4   digit from switches (0-F accepted)
//  Validate  in   1   one-cycle debounced pulse, same pulse seen by FSM
//  ShiftA    in   1   FSM in entry states (Digit3..Digit0)
//  ShiftB    in   1   FSM in set states (Set3..Set0)
//  RSTA      in   1   FSM in S_Locked: clear A and S
//  Select    in   3   display/phase select from FSM
//  Pass      out  1   A == B (combinational from registers)
//  Reverse   out  1   A == digit-reversed B and A != B (combinational)
//  seg       out  7   {g,f,e,d,c,b,a}, active-low, registered
//  an        out  4   anode enables, active-low, one-hot-low, registered; an[3] = leftmost
// BEHAVIOUR
//  Reset: A=0, S=0, B=DEFAULT_CODE, scan counter=0, digit index=0, an=4'b1111, seg=7'h7F.
//  Register priority each posedge: RSTA > shift. RSTA=1 -> A<=0, S<=0 (B untouched).
//  ShiftA && Validate -> A <= {A[11:0], Digit_In}. Captured on the same edge the FSM advances.
//  ShiftB && Validate && Select!=3'b100 -> S <= {S[11:0], Digit_In}.
//  ShiftB && Validate && Select==3'b100 -> B <= {S[11:0], Digit_In}; S <= 0 (commit).
//  Aborted set sequence (Change -> Set3) leaves B unchanged; stale S is shifted out by next
//  4 digits, so only a full 4-digit sequence alters B.
//  ShiftA and ShiftB both high: treat as ShiftA only (illegal from FSM; must not corrupt B).
//  Validate with neither shift high: no register change.
//  Pass/Reverse valid the cycle after A's final shift (FSM in S_Compare samples there).
//  Reverse = (A == {B[3:0],B[7:4],B[11:8],B[15:12]}) && !Pass; palindromic B never alarms.
//  Scan: counter increments every clock; on wrap, digit index 0..3 advances (3 -> 0);
//  an/seg for new index registered on the following edge (1-cycle output latency).
//  Glyph per Select, left->right:
//   000 "L O C k";  001 Digit_In,-,-,-;  010 -,Digit_In,-,-;  011 -,-,Digit_In,-;
//   100 -,-,-,Digit_In;  101 all blank (an=1111);  110 "P A S S";  111 "F A I L".
//  Digit_In glyph is standard hex 0-F; '-' = segment g only (seg=7'b0111111).
//  Select change mid-scan: takes effect on next registered update, no blanking glitch needed.
//  RST mid-operation: all state to reset values immediately, display blank until first scan.
// TESTING
//  RST, Select=000, run 4 wraps -> an cycles 1110,1101,1011,0111 showing k,C,O,L; B=16'h1234.
//  RSTA, then 4x (ShiftA,Validate) with 1,2,3,4 -> A=16'h1234, Pass=1, Reverse=0.
//  Enter 4,3,2,1 -> A=16'h4321, Pass=0, Reverse=1; enter 1,2,3,5 -> Pass=0, Reverse=0.
//  ShiftB: 9,8 (Select 001,010), RSTA-free abort, then 7,6,5,4 with Select 001..100 ->
//   B=16'h7654 only after 4th Validate; B unchanged after first two digits.
//  Set B=16'h1221 then enter 1,2,2,1 -> Pass=1, Reverse=0 (palindrome).
//  Assert RST during entry after 2 digits -> A=0, B=DEFAULT_CODE, an=1111 same cycle.

Source files
------------

// File: rtl/lock_datapath_if.sv
// rtl/lock_datapath_if.sv - control/status bundle between the lock FSM and its datapath
interface lock_datapath_if;
  logic [3:0] Digit_In;
  logic       Validate;
  logic       ShiftA;
  logic       ShiftB;
  logic       RSTA;
  logic [2:0] Select;
  logic       Pass;
  logic       Reverse;

  modport master (
    output Digit_In, Validate, ShiftA, ShiftB, RSTA, Select,
    input  Pass, Reverse
  );

  modport slave (
    input  Digit_In, Validate, ShiftA, ShiftB, RSTA, Select,
    output Pass, Reverse
  );
endinterface

// File: rtl/lock_datapath.sv
// rtl/lock_datapath.sv - code registers A/S/B, match detection and 4-digit 7-seg scan
module lock_datapath #(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned REFRESH_DIV  = 17
) (
  input  logic                 CLK,
  input  logic                 RST,
  lock_datapath_if.slave       ctrl,
  output logic [6:0]           seg,
  output logic [3:0]           an
);
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_BLANK = 7'h7F;
  // Word glyphs packed left->right, digit index 3 in the top 7 bits
  localparam logic [27:0] W_LOCK = {7'h47, 7'h40, 7'h46, 7'h0B};
  localparam logic [27:0] W_PASS = {7'h0C, 7'h08, 7'h12, 7'h12};
  localparam logic [27:0] W_FAIL = {7'h0E, 7'h08, 7'h4F, 7'h47};

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
    endcase
  endfunction

  logic [15:0]            a_q, a_d, s_q, s_d, b_q, b_d;
  logic [REFRESH_DIV-1:0] cnt_q, cnt_d;
  logic [1:0]             idx_q, idx_d, disp_idx_q, disp_idx_d;
  logic                   upd_q, upd_d;
  logic [3:0]             an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   wrap;
  logic [1:0]             dig_pos;
  logic [15:0]            b_rev;
  logic                   match;

  always_comb begin
    a_d = a_q;
    s_d = s_q;
    b_d = b_q;
    if (ctrl.RSTA) begin
      a_d = '0;
      s_d = '0;
    end else if (ctrl.Validate && ctrl.ShiftA) begin
      a_d = {a_q[11:0], ctrl.Digit_In};
    end else if (ctrl.Validate && ctrl.ShiftB) begin
      if (ctrl.Select == 3'b100) begin
        b_d = {s_q[11:0], ctrl.Digit_In};
        s_d = '0;
      end else begin
        s_d = {s_q[11:0], ctrl.Digit_In};
      end
    end
  end

  assign b_rev        = {b_q[3:0], b_q[7:4], b_q[11:8], b_q[15:12]};
  assign match        = (a_q == b_q);
  assign ctrl.Pass    = match;
  assign ctrl.Reverse = (a_q == b_rev) && !match;

  // The index that wrapped is latched so its glyph lands exactly one edge later
  assign wrap       = &cnt_q;
  assign cnt_d      = cnt_q + 1'b1;
  assign idx_d      = wrap ? idx_q + 2'd1 : idx_q;
  assign disp_idx_d = wrap ? idx_q : disp_idx_q;
  assign upd_d      = wrap;
  assign dig_pos    = 2'(3'd4 - ctrl.Select);

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (upd_q) begin
      an_d = ~(4'b0001 << disp_idx_q);
      case (ctrl.Select)
        3'b000:  seg_d = W_LOCK[disp_idx_q*7 +: 7];
        3'b101: begin
          an_d  = 4'hF;
          seg_d = G_BLANK;
        end
        3'b110:  seg_d = W_PASS[disp_idx_q*7 +: 7];
        3'b111:  seg_d = W_FAIL[disp_idx_q*7 +: 7];
        default: seg_d = (disp_idx_q == dig_pos) ? hex_glyph(ctrl.Digit_In) : G_DASH;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q        <= '0;
      s_q        <= '0;
      b_q        <= DEFAULT_CODE;
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_idx_q <= '0;
      upd_q      <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= G_BLANK;
    end else begin
      a_q        <= a_d;
      s_q        <= s_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_idx_q <= disp_idx_d;
      upd_q      <= upd_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_lock_datapath.sv
// tb/tb_lock_datapath.sv - scoreboard bench for lock_datapath
module tb_lock_datapath;
  logic       CLK;
  logic       RST;
  logic [6:0] seg;
  logic [3:0] an;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         disp_idx = 0;
  logic       disp_en = 1'b0;
  logic [10:0] prev_disp = {4'hF, 7'h7F};

  typedef struct {
    string       name;
    logic [12:0] exp;
    logic [12:0] mask;
  } sb_t;

  sb_t         sb_q[$];
  logic [10:0] disp_q[$];
  sb_t         e;
  logic [12:0] act;
  logic [10:0] ed;

  localparam logic [12:0] M_PR  = 13'h1800;
  localparam logic [12:0] M_ALL = 13'h1FFF;

  lock_datapath_if bus();

  lock_datapath #(.DEFAULT_CODE(16'h1234), .REFRESH_DIV(3)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ctrl (bus),
    .seg  (seg),
    .an   (an)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) cyc = 0;
    else     cyc = cyc + 1;
  end

  always @(negedge CLK) begin
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {bus.Pass, bus.Reverse, an, seg};
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got {Pass,Rev,an,seg}=%h expected %h (mask %h)", e.name, act, e.exp, e.mask);
      end
    end
    if (disp_en && ({an, seg} !== prev_disp)) begin
      checks++;
      if (disp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_unexpected: got an=%b seg=%h expected no change", an, seg);
      end else begin
        ed = disp_q.pop_front();
        if ({an, seg} !== ed) begin
          errors++;
          $display("FAIL disp_%0d: got an=%b seg=%h expected an=%b seg=%h",
                   disp_idx, an, seg, ed[10:7], ed[6:0]);
        end
      end
      disp_idx++;
    end
    prev_disp = {an, seg};
  end

  task automatic check(input string name, input logic [12:0] exp, input logic [12:0] mask);
    sb_q.push_back('{name, exp, mask});
    @(negedge CLK);
    #1;
  endtask

  task automatic shift(input logic sa, input logic sb, input logic [2:0] sel, input logic [3:0] d);
    @(posedge CLK);
    #2;
    bus.ShiftA = sa;  bus.ShiftB = sb;  bus.Select = sel;
    bus.Digit_In = d; bus.Validate = 1'b1;
    @(posedge CLK);
    #2;
    bus.ShiftA = 1'b0; bus.ShiftB = 1'b0; bus.Validate = 1'b0;
  endtask

  task automatic rsta();
    @(posedge CLK);
    #2;
    bus.RSTA = 1'b1;
    @(posedge CLK);
    #2;
    bus.RSTA = 1'b0;
  endtask

  task automatic enter(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) shift(1'b1, 1'b0, 3'b001, code[i*4 +: 4]);
  endtask

  task automatic push_word(input logic [27:0] w);
    for (int i = 0; i < 4; i++) disp_q.push_back({~(4'b0001 << i), w[i*7 +: 7]});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    bus.Digit_In = 4'h0; bus.Validate = 1'b0; bus.ShiftA = 1'b0;
    bus.ShiftB = 1'b0;   bus.RSTA = 1'b0;     bus.Select = 3'b000;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    disp_en = 1'b1;
    push_word({7'h47, 7'h40, 7'h46, 7'h0B});
    @(posedge CLK);
    #2;
    check("reset_state", {2'b00, 4'hF, 7'h7F}, M_ALL);

    // Each phase spans four 8-clock scan periods; Select changes between updates
    wait_cyc(36);
    bus.Select = 3'b001; bus.Digit_In = 4'hA;
    push_word({7'h08, 7'h3F, 7'h3F, 7'h3F});
    wait_cyc(68);
    bus.Select = 3'b100; bus.Digit_In = 4'h7;
    push_word({7'h3F, 7'h3F, 7'h3F, 7'h78});
    wait_cyc(100);
    bus.Select = 3'b110;
    push_word({7'h0C, 7'h08, 7'h12, 7'h12});
    wait_cyc(132);
    bus.Select = 3'b111;
    push_word({7'h0E, 7'h08, 7'h4F, 7'h47});
    wait_cyc(164);
    bus.Select = 3'b101;
    disp_q.push_back({4'hF, 7'h7F});
    wait_cyc(196);
    disp_en = 1'b0;
    checks++;
    if (disp_q.size() != 0) begin
      errors++;
      $display("FAIL disp_drain: got %0d pending updates expected 0", disp_q.size());
    end

    rsta();
    enter(16'h1234);
    check("pass_1234", {2'b10, 11'h0}, M_PR);
    shift(1'b0, 1'b0, 3'b001, 4'h9);
    check("validate_only", {2'b10, 11'h0}, M_PR);
    rsta();
    enter(16'h4321);
    check("reverse_4321", {2'b01, 11'h0}, M_PR);
    rsta();
    enter(16'h1235);
    check("nomatch_1235", {2'b00, 11'h0}, M_PR);

    @(posedge CLK);
    #2;
    bus.RSTA = 1'b1; bus.ShiftA = 1'b1; bus.Validate = 1'b1; bus.Digit_In = 4'h1;
    @(posedge CLK);
    #2;
    bus.RSTA = 1'b0; bus.ShiftA = 1'b0; bus.Validate = 1'b0;
    shift(1'b1, 1'b0, 3'b001, 4'h2);
    shift(1'b1, 1'b0, 3'b001, 4'h3);
    shift(1'b1, 1'b0, 3'b001, 4'h4);
    check("rsta_priority", {2'b00, 11'h0}, M_PR);

    rsta();
    enter(16'h1234);
    shift(1'b0, 1'b1, 3'b001, 4'h9);
    shift(1'b0, 1'b1, 3'b010, 4'h8);
    check("b_after_abort", {2'b10, 11'h0}, M_PR);
    shift(1'b0, 1'b1, 3'b001, 4'h7);
    shift(1'b0, 1'b1, 3'b010, 4'h6);
    shift(1'b0, 1'b1, 3'b011, 4'h5);
    check("b_before_commit", {2'b10, 11'h0}, M_PR);
    shift(1'b0, 1'b1, 3'b100, 4'h4);
    check("b_after_commit", {2'b00, 11'h0}, M_PR);
    rsta();
    enter(16'h7654);
    check("pass_7654", {2'b10, 11'h0}, M_PR);
    rsta();
    enter(16'h4567);
    check("reverse_4567", {2'b01, 11'h0}, M_PR);

    rsta();
    shift(1'b1, 1'b0, 3'b001, 4'h7);
    shift(1'b1, 1'b0, 3'b010, 4'h6);
    shift(1'b1, 1'b0, 3'b011, 4'h5);
    shift(1'b1, 1'b1, 3'b100, 4'h4);
    check("both_shifts", {2'b10, 11'h0}, M_PR);

    shift(1'b0, 1'b1, 3'b001, 4'h1);
    shift(1'b0, 1'b1, 3'b010, 4'h2);
    shift(1'b0, 1'b1, 3'b011, 4'h2);
    shift(1'b0, 1'b1, 3'b100, 4'h1);
    rsta();
    enter(16'h1221);
    check("palindrome", {2'b10, 11'h0}, M_PR);

    rsta();
    bus.Select = 3'b000;
    shift(1'b1, 1'b0, 3'b000, 4'h1);
    shift(1'b1, 1'b0, 3'b000, 4'h2);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    check("rst_mid_entry", {2'b00, 4'hF, 7'h7F}, M_ALL);
    RST = 1'b0;
    enter(16'h1234);
    check("pass_after_rst", {2'b10, 11'h0}, M_PR);

    repeat (2) @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
